// File: rtl/posit_7b_issue_queue.sv
// posit_7b_issue_queue
//   Operand issue queue in front of the 7-bit posit (es=1) add/sub stage.
//   Requests are prepared at enqueue: b is two's-complement negated for
//   subtract, and NaR/zero operands are classified into a bypass flag and a
//   bypass result. Entries sit in a circular buffer and the head is presented
//   to the adder stage straight from storage registers.
//
// Ports
//   clk, rst        clock; asynchronous active-low reset
//   in_valid/ready  request handshake (in_ready = count < DEPTH)
//   in_a, in_b      operands; in_sub selects a - b
//   out_valid/ready head handshake (out_valid = count != 0)
//   out_a, out_b    head operands (out_b already negated for subtract)
//   out_byp         head is a special case; use out_byp_val as the result
//   out_byp_val     special-case result
//   count           entries currently held
module posit_7b_issue_queue #(
  parameter int WIDTH = 7,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         in_a,
  input  logic [WIDTH-1:0]         in_b,
  input  logic                     in_sub,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_a,
  output logic [WIDTH-1:0]         out_b,
  output logic                     out_byp,
  output logic [WIDTH-1:0]         out_byp_val,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0]      FULL_CNT = (PW+1)'(DEPTH);
  localparam logic [WIDTH-1:0] NAR      = {1'b1, {(WIDTH-1){1'b0}}};

  logic [WIDTH-1:0] a_q   [DEPTH];
  logic [WIDTH-1:0] b_q   [DEPTH];
  logic             byp_q [DEPTH];
  logic [WIDTH-1:0] val_q [DEPTH];

  logic [PW-1:0] wp_q, wp_d;
  logic [PW-1:0] rp_q, rp_d;
  logic [PW:0]   cnt_q, cnt_d;

  logic             push, pop;
  logic [WIDTH-1:0] nb;
  logic             byp_n;
  logic [WIDTH-1:0] val_n;

  // Handshake flags depend only on the registered count.
  assign in_ready  = (cnt_q != FULL_CNT);
  assign out_valid = (cnt_q != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  // Operand preparation. Negation leaves NaR and zero unchanged, so
  // classification on the stored b needs no subtract-specific cases.
  always_comb begin
    nb    = in_sub ? WIDTH'(~in_b + 1'b1) : in_b;
    byp_n = 1'b0;
    val_n = '0;
    if (in_a == NAR || nb == NAR) begin
      byp_n = 1'b1;
      val_n = NAR;
    end else if (in_a == '0) begin
      byp_n = 1'b1;
      val_n = nb;
    end else if (nb == '0) begin
      byp_n = 1'b1;
      val_n = in_a;
    end
  end

  always_comb begin
    wp_d  = push ? wp_q + 1'b1 : wp_q;
    rp_d  = pop  ? rp_q + 1'b1 : rp_q;
    cnt_d = cnt_q;
    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        a_q[i]   <= '0;
        b_q[i]   <= '0;
        byp_q[i] <= 1'b0;
        val_q[i] <= '0;
      end
    end else begin
      wp_q  <= wp_d;
      rp_q  <= rp_d;
      cnt_q <= cnt_d;
      if (push) begin
        a_q[wp_q]   <= in_a;
        b_q[wp_q]   <= nb;
        byp_q[wp_q] <= byp_n;
        val_q[wp_q] <= val_n;
      end
    end
  end

  // Head is read straight from storage: no fall-through from the request side.
  assign out_a       = a_q[rp_q];
  assign out_b       = b_q[rp_q];
  assign out_byp     = byp_q[rp_q];
  assign out_byp_val = val_q[rp_q];
  assign count       = cnt_q;

endmodule

// File: tb/tb_posit_7b_issue_queue.sv
module tb_posit_7b_issue_queue;

  localparam int W = 7;
  localparam int D = 4;

  logic         clk, rst_n;
  logic         in_valid, in_ready, in_sub;
  logic [W-1:0] in_a, in_b;
  logic         out_valid, out_ready, out_byp;
  logic [W-1:0] out_a, out_b, out_byp_val;
  logic [2:0]   count;

  posit_7b_issue_queue #(.WIDTH(W), .DEPTH(D)) dut (
    .clk(clk), .rst(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_sub(in_sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_a(out_a), .out_b(out_b), .out_byp(out_byp), .out_byp_val(out_byp_val),
    .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int a;
    int b;
    int byp;
    int val;
  } ent_t;

  ent_t mq[$];
  int n_tests = 0;
  int n_fail  = 0;

  // Reference: posit words as integers 0..127, NaR = 64.
  function automatic ent_t mk(int a, int b, int sub);
    ent_t e;
    e.a = a;
    e.b = sub ? (128 - b) % 128 : b;
    if (e.a == 64 || e.b == 64) begin e.byp = 1; e.val = 64; end
    else if (e.a == 0)          begin e.byp = 1; e.val = e.b; end
    else if (e.b == 0)          begin e.byp = 1; e.val = e.a; end
    else                        begin e.byp = 0; e.val = 0; end
    return e;
  endfunction

  task automatic chk(input string tag, input int obs, input int exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $display("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      $error("%s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("count", int'(count), mq.size());
    chk("in_ready", int'(in_ready), (mq.size() < D) ? 1 : 0);
    chk("out_valid", int'(out_valid), (mq.size() != 0) ? 1 : 0);
    if (mq.size() != 0) begin
      chk("out_a", int'(out_a), mq[0].a);
      chk("out_b", int'(out_b), mq[0].b);
      chk("out_byp", int'(out_byp), mq[0].byp);
      chk("out_byp_val", int'(out_byp_val), mq[0].val);
    end
  endtask

  // One clock: the model sees the same edge using pre-edge occupancy.
  task automatic step();
    bit do_push, do_pop;
    ent_t e;
    @(posedge clk);
    do_push = in_valid && (mq.size() < D);
    do_pop  = out_ready && (mq.size() != 0);
    e = mk(int'(in_a), int'(in_b), int'(in_sub));
    if (do_pop)  void'(mq.pop_front());
    if (do_push) mq.push_back(e);
    #1;
    check_all();
  endtask

  function automatic logic [W-1:0] rnd_word();
    int r;
    r = $urandom_range(0, 7);
    if (r == 0) return '0;
    if (r == 1) return 7'h40;
    return W'($urandom);
  endfunction

  task automatic rnd_req();
    in_a   = rnd_word();
    in_b   = rnd_word();
    in_sub = 1'($urandom);
  endtask

  // Push one request into an empty queue, check the prepared head against
  // hand-computed constants, then pop it.
  task automatic single(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                        input int eb, input int ebyp, input int ev);
    out_ready = 1'b0;
    in_valid = 1'b1; in_a = a; in_b = b; in_sub = s;
    step();
    in_valid = 1'b0;
    chk("dir_out_b", int'(out_b), eb);
    chk("dir_byp", int'(out_byp), ebyp);
    chk("dir_byp_val", int'(out_byp_val), ev);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_a = '0; in_b = '0; in_sub = 1'b0;
    #1;
    chk("rst_count", int'(count), 0);
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_out_valid", int'(out_valid), 0);
    #1 rst_n = 1'b1;

    // Subtract negation and special cases.
    single(7'h11, 7'h05, 1'b1, 'h7B, 0, 0);
    single(7'h11, 7'h05, 1'b0, 'h05, 0, 0);
    single(7'h11, 7'h40, 1'b1, 'h40, 1, 'h40);
    single(7'h00, 7'h12, 1'b1, 'h6E, 1, 'h6E);
    single(7'h23, 7'h00, 1'b0, 'h00, 1, 'h23);

    // Fill: fifth push refused.
    out_ready = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin rnd_req(); step(); end
    chk("full_count", int'(count), 4);
    chk("full_in_ready", int'(in_ready), 0);
    in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 4; i++) step();
    chk("drain_count", int'(count), 0);

    // Steady push/pop at count=2 across pointer wrap.
    out_ready = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 2; i++) begin rnd_req(); step(); end
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      rnd_req(); step();
      chk("steady_count", int'(count), 2);
    end
    in_valid = 1'b0;
    for (int i = 0; i < 2; i++) step();

    // Empty boundary: no pop in the push cycle.
    out_ready = 1'b1; in_valid = 1'b1; rnd_req();
    step();
    in_valid = 1'b0;
    chk("empty_push_count", int'(count), 1);
    chk("empty_push_valid", int'(out_valid), 1);
    step();
    chk("empty_pop_count", int'(count), 0);

    // Asynchronous reset mid-stream with three entries.
    out_ready = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin rnd_req(); step(); end
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    mq.delete();
    chk("mid_rst_count", int'(count), 0);
    chk("mid_rst_valid", int'(out_valid), 0);
    chk("mid_rst_ready", int'(in_ready), 1);
    chk("mid_rst_a", int'(out_a), 0);
    chk("mid_rst_b", int'(out_b), 0);
    chk("mid_rst_byp", int'(out_byp), 0);
    chk("mid_rst_val", int'(out_byp_val), 0);
    #2 rst_n = 1'b1;
    in_valid = 1'b1; rnd_req(); step();
    in_valid = 1'b0; out_ready = 1'b1; step();

    // Random traffic.
    for (int i = 0; i < 300; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      rnd_req();
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/posit_7b_issue_queue.md
# posit_7b_issue_queue

Operand issue queue that sits directly upstream of the 7-bit posit add/subtract stage (WIDTH=7, es=1). It accepts add/sub requests over a valid/ready handshake, buffers up to DEPTH of them, and performs operand preparation at enqueue: two's-complement negation of b for subtract, and NaR/zero special-case classification. The head entry is presented to the adder stage over a second valid/ready handshake, along with a bypass result the downstream stage uses for special cases.

## Interface
- WIDTH, 7, posit word width in bits
- DEPTH, 4, queue entries; power of two, ≥2
- clk  input  1  clock, all state updates on rising edge
- rst  input  1  asynchronous, active-low reset
- in_valid  input  1  request present
- in_ready  output  1  queue can accept; equals (count < DEPTH)
- in_a  input  WIDTH  operand a
- in_b  input  WIDTH  operand b
- in_sub  input  1  1 = a − b, 0 = a + b
- out_valid  output  1  head entry present; equals (count != 0)
- out_ready  input  1  adder stage accepts head
- out_a  output  WIDTH  head operand a
- out_b  output  WIDTH  head operand b, already negated if sub
- out_byp  output  1  head is a special case; adder result must be replaced by out_byp_val
- out_byp_val  output  WIDTH  special-case result
- count  output  $clog2(DEPTH)+1  entries currently held

## Operation
- Push on a rising edge with in_valid && in_ready. Pop on a rising edge with out_valid && out_ready.
- Stored b = in_sub ? (~in_b + 1) mod 2^WIDTH : in_b. NaR (1 followed by zeros, 7'b1000000) and zero map to themselves, so no special handling is needed.
- Classification is computed on the stored (post-negation) operands and registered with the entry:
  - a == NaR or b == NaR: byp=1, val=NaR.
  - else a == 0: byp=1, val=b.
  - else b == 0: byp=1, val=a.
  - else: byp=0, val=0.
- Storage is a circular buffer with write pointer wp, read pointer rp, and occupancy count.
  - Pointers wrap modulo DEPTH.
  - count: +1 on push only, −1 on pop only, unchanged on simultaneous push and pop.
- Full (count == DEPTH): in_ready=0. There is no push-through on full, even if a pop occurs in the same cycle.
- Empty (count == 0): out_valid=0. out_* data are don't-care but must be stable register outputs (the entry at rp). There is no combinational fall-through of in_* to out_*.
- Request field changes while a handshake is stalled are not this block's concern. Output fields must hold stable while out_valid=1 and out_ready=0.
- States are implied by count: EMPTY (0), PARTIAL, FULL (DEPTH).

## Timing
- Reset (rst=0, asynchronous) forces:
  - wp=rp=count=0 and all entry storage to 0.
  - out_valid=0, in_ready=1, out_a=out_b=out_byp_val=0, out_byp=0.
- Reset asserted mid-operation discards all entries immediately, without waiting for a clock edge.
- Deassertion takes effect at the first rising edge after rst=1.
- Latency: an entry pushed at edge N is visible at the outputs with out_valid=1 from just after edge N. It can be popped at edge N+1 at the earliest.
- Throughput: one push and one pop per cycle sustained in the PARTIAL state.
- in_ready and out_valid are pure functions of registered count (no combinational path from in_valid or out_ready).

## Test plan
- **Reset values:** assert rst=0 mid-stream with 3 entries queued -> count=0, out_valid=0, in_ready=1 and all outputs 0 before the next edge. After release, the first pop returns the first post-reset push.
- **Subtract negation:** push a=0x11, b=0x05, sub=1 -> out_b=0x7B, out_byp=0. Push a=0x11, b=0x05, sub=0 -> out_b=0x05.
- **Special cases:**
  - b=0x40 (NaR), sub=1 -> out_b=0x40, out_byp=1, out_byp_val=0x40.
  - a=0x00, b=0x12, sub=1 -> out_byp=1, out_byp_val=0x6E.
  - a=0x23, b=0x00 -> out_byp_val=0x23.
- **Fill and order:** with DEPTH=4 and out_ready=0, push 5 requests -> the 5th is not accepted, in_ready=0 and count=4. Then out_ready=1 -> the 4 entries drain in push order and count reaches 0 after 4 edges.
- **Simultaneous push/pop and wrap:** with count=2, hold in_valid=out_ready=1 for 10 cycles -> count stays 2, and the output sequence equals the input sequence delayed by 2 entries across pointer wrap.
- **Empty boundary:** with count=0, out_ready=1 and one push -> no pop in the push cycle, out_valid=1 on the next cycle, pop on the following edge, count returns to 0.
